// File: rtl/ercm_share_ctrl.sv
// ercm_share_ctrl: two-stage pipelined scheduler that time-shares one
// combinational 8x8 approximate multiplier among NREQ requesters.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_a/req_b      per-requester operand requests (8-bit lanes)
//   req_ready                  one-hot accept, combinational
//   cfg_we/cfg_id/cfg_mask     per-requester mask table write port
//   mul_a/mul_b/mul_mask       registered operands to the multiplier (S1)
//   mul_p                      multiplier product (combinational return)
//   rsp_valid/rsp_ready        response handshake (S2)
//   rsp_id/rsp_data            requester ID and product of the response
//   occupancy                  number of valid pipeline stages (0..2)
module ercm_share_ctrl #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned IDW          = 2,
    parameter logic [6:0]  DEFAULT_MASK = 7'h7F
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 cfg_we,
    input  logic [IDW-1:0]       cfg_id,
    input  logic [6:0]           cfg_mask,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    output logic [6:0]           mul_mask,
    input  logic [15:0]          mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_data,
    output logic [1:0]           occupancy
);

    localparam int unsigned DW = 8;
    localparam int unsigned MW = 7;
    localparam int unsigned PW = 16;

    // Pipeline state
    logic            s1_v_q, s1_v_d;
    logic [DW-1:0]   s1_a_q, s1_a_d;
    logic [DW-1:0]   s1_b_q, s1_b_d;
    logic [MW-1:0]   s1_mask_q, s1_mask_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            s2_v_q, s2_v_d;
    logic [PW-1:0]   s2_data_q, s2_data_d;
    logic [IDW-1:0]  s2_id_q, s2_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [1:0]      occ_q, occ_d;
    logic [MW-1:0]   mask_tbl_q [NREQ];
    logic [MW-1:0]   mask_tbl_d [NREQ];

    // Arbitration / handshake
    logic            s2_adv;
    logic            s1_adv;
    logic            accept;
    logic            found;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] gnt_oh;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic [MW-1:0]   sel_mask;

    assign s2_adv = !s2_v_q || rsp_ready;
    assign s1_adv = !s1_v_q || s2_adv;
    // rst_n gating keeps req_ready low for the whole reset window.
    assign accept = rst_n && s1_adv && (|req_valid);
    assign req_ready = accept ? gnt_oh : '0;

    // Round-robin search: first pass covers ptr..NREQ-1, second pass wraps to 0.
    always_comb begin
        found    = 1'b0;
        gnt_id   = '0;
        gnt_oh   = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (i >= 32'(ptr_q))) begin
                found     = 1'b1;
                gnt_id    = IDW'(i);
                gnt_oh[i] = 1'b1;
                sel_a     = req_a[DW*i +: DW];
                sel_b     = req_b[DW*i +: DW];
                sel_mask  = mask_tbl_q[i];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                gnt_id    = IDW'(i);
                gnt_oh[i] = 1'b1;
                sel_a     = req_a[DW*i +: DW];
                sel_b     = req_b[DW*i +: DW];
                sel_mask  = mask_tbl_q[i];
            end
        end
    end

    // Next-state logic for pipeline, pointer and mask table
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mask_d  = s1_mask_q;
        s1_id_d    = s1_id_q;
        s2_v_d     = s2_v_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        ptr_d      = ptr_q;
        mask_tbl_d = mask_tbl_q;

        // Operands hold their last value when S1 drains to avoid toggling the multiplier.
        if (accept) begin
            s1_v_d    = 1'b1;
            s1_a_d    = sel_a;
            s1_b_d    = sel_b;
            s1_mask_d = sel_mask;
            s1_id_d   = gnt_id;
            ptr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        if (s2_adv) begin
            s2_v_d    = s1_v_q;
            s2_data_d = mul_p;
            s2_id_d   = s1_id_q;
        end

        // Out-of-range ids match no entry and are dropped; accept above used the old mask.
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (cfg_we && (cfg_id == IDW'(i))) begin
                mask_tbl_d[i] = cfg_mask;
            end
        end

        occ_d = 2'(s1_v_d) + 2'(s2_v_d);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_mask_q <= DEFAULT_MASK;
            s1_id_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= '0;
            ptr_q     <= '0;
            occ_q     <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                mask_tbl_q[i] <= DEFAULT_MASK;
            end
        end else begin
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mask_q  <= s1_mask_d;
            s1_id_q    <= s1_id_d;
            s2_v_q     <= s2_v_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            ptr_q      <= ptr_d;
            occ_q      <= occ_d;
            mask_tbl_q <= mask_tbl_d;
        end
    end

    assign mul_a     = s1_a_q;
    assign mul_b     = s1_b_q;
    assign mul_mask  = s1_mask_q;
    assign rsp_valid = s2_v_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_data_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_ercm_share_ctrl.sv
// Directed bench for ercm_share_ctrl: a 4-requester instance covers the main
// scheduling behaviour and a 3-requester instance covers pointer wrap.
// The multiplier is modelled as an exact 8x8 product.
module tb_ercm_share_ctrl;

    logic        clk;
    logic        rst_n;

    // NREQ = 4 instance
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        cfg_we;
    logic [1:0]  cfg_id;
    logic [6:0]  cfg_mask;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [6:0]  mul_mask;
    logic [15:0] mul_p;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic [1:0]  occupancy;

    // NREQ = 3 instance
    logic [2:0]  req_valid3;
    logic [23:0] req_a3;
    logic [23:0] req_b3;
    logic [2:0]  req_ready3;
    logic        cfg_we3;
    logic [1:0]  cfg_id3;
    logic [6:0]  cfg_mask3;
    logic [7:0]  mul_a3;
    logic [7:0]  mul_b3;
    logic [6:0]  mul_mask3;
    logic [15:0] mul_p3;
    logic        rsp_valid3;
    logic        rsp_ready3;
    logic [1:0]  rsp_id3;
    logic [15:0] rsp_data3;
    logic [1:0]  occupancy3;

    int n_tests = 0;
    int n_fail  = 0;

    // Backpressure expectations per cycle c0..c11
    int bp_ready [12] = '{4, 4, 4, 0, 0, 0, 0, 4, 4, 0, 0, 0};
    int bp_rv    [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int bp_data  [12] = '{0, 0, 2, 4, 4, 4, 4, 4, 6, 16, 18, 0};
    int bp_occ   [12] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 1, 0};
    // Round-robin products: a = {2,3,4,5}, b = 3
    int rr_data  [4]  = '{6, 9, 12, 15};

    assign mul_p  = {8'h00, mul_a}  * {8'h00, mul_b};
    assign mul_p3 = {8'h00, mul_a3} * {8'h00, mul_b3};

    ercm_share_ctrl #(.NREQ(4), .IDW(2), .DEFAULT_MASK(7'h7F)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .cfg_we    (cfg_we),
        .cfg_id    (cfg_id),
        .cfg_mask  (cfg_mask),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_mask  (mul_mask),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .occupancy (occupancy)
    );

    ercm_share_ctrl #(.NREQ(3), .IDW(2), .DEFAULT_MASK(7'h7F)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid3),
        .req_a     (req_a3),
        .req_b     (req_b3),
        .req_ready (req_ready3),
        .cfg_we    (cfg_we3),
        .cfg_id    (cfg_id3),
        .cfg_mask  (cfg_mask3),
        .mul_a     (mul_a3),
        .mul_b     (mul_b3),
        .mul_mask  (mul_mask3),
        .mul_p     (mul_p3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready3),
        .rsp_id    (rsp_id3),
        .rsp_data  (rsp_data3),
        .occupancy (occupancy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        cfg_we     = 1'b0;
        cfg_id     = '0;
        cfg_mask   = '0;
        rsp_ready  = 1'b1;
        req_valid3 = '0;
        req_a3     = '0;
        req_b3     = '0;
        cfg_we3    = 1'b0;
        cfg_id3    = '0;
        cfg_mask3  = '0;
        rsp_ready3 = 1'b1;

        // Reset values, req_ready held low even with requests pending
        repeat (2) tick();
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_mul_mask",  32'(mul_mask), 32'h7F);
        check("rst_mul_a",     32'(mul_a), 0);
        check("rst_rsp_id",    32'(rsp_id), 0);
        check("rst_rsp_data",  32'(rsp_data), 0);
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single request from requester 1
        req_valid = 4'b0010;
        req_a     = 32'h0000_0100;
        req_b     = 32'h0000_0500;
        #1;
        check("single_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        check("single_mul_a",    32'(mul_a), 1);
        check("single_mul_b",    32'(mul_b), 5);
        check("single_mul_mask", 32'(mul_mask), 32'h7F);
        check("single_occ",      32'(occupancy), 1);
        check("single_rv_early", 32'(rsp_valid), 0);
        tick();
        check("single_rv",   32'(rsp_valid), 1);
        check("single_id",   32'(rsp_id), 1);
        check("single_data", 32'(rsp_data), 32'h0005);
        tick();

        // Requester 3 alone moves the pointer back to 0
        req_valid = 4'b1000;
        req_a     = 32'h0504_0302;
        req_b     = 32'h0303_0303;
        #1;
        check("rr_pre_ready", 32'(req_ready), 32'h8);
        check("rr_pre_rv",    32'(rsp_valid), 0);

        // Round robin with all four requesters valid
        for (int j = 0; j < 8; j++) begin
            tick();
            req_valid = (j < 6) ? 4'hF : 4'h0;
            #1;
            check("rr_grant", 32'(req_ready), (j < 6) ? (1 << (j % 4)) : 0);
            if (j == 1) begin
                check("rr_pre_rsp_id", 32'(rsp_id), 3);
            end
            if (j >= 1) begin
                check("rr_rv", 32'(rsp_valid), 1);
            end
            if (j >= 2) begin
                check("rr_rsp_id",   32'(rsp_id), (j - 2) % 4);
                check("rr_rsp_data", 32'(rsp_data), rr_data[(j - 2) % 4]);
            end
        end
        tick();
        check("rr_drain_rv",  32'(rsp_valid), 0);
        check("rr_drain_occ", 32'(occupancy), 0);

        // Backpressure: stream from requester 2, rsp_ready low for c3..c6
        for (int c = 0; c < 12; c++) begin
            tick();
            rsp_ready = !(c >= 3 && c <= 6);
            req_valid = (c < 9) ? 4'b0100 : 4'b0000;
            req_a     = {8'h00, 8'(c + 1), 16'h0000};
            req_b     = 32'h0002_0000;
            #1;
            check("bp_ready", 32'(req_ready), bp_ready[c]);
            check("bp_rv",    32'(rsp_valid), bp_rv[c]);
            check("bp_occ",   32'(occupancy), bp_occ[c]);
            if (bp_rv[c] != 0) begin
                check("bp_data", 32'(rsp_data), bp_data[c]);
                check("bp_id",   32'(rsp_id), 2);
            end
        end
        rsp_ready = 1'b1;

        // Mask write racing an accept for the same requester
        tick();
        req_valid = 4'b1000;
        req_a     = 32'h1000_0000;
        req_b     = 32'h0F00_0000;
        cfg_we    = 1'b1;
        cfg_id    = 2'd3;
        cfg_mask  = 7'h0F;
        #1;
        check("mask_ready0", 32'(req_ready), 32'h8);
        tick();
        cfg_we = 1'b0;
        #1;
        check("mask_ready1", 32'(req_ready), 32'h8);
        check("mask_old",    32'(mul_mask), 32'h7F);
        check("mask_mul_a",  32'(mul_a), 32'h10);
        check("mask_mul_b",  32'(mul_b), 32'h0F);
        tick();
        req_valid = '0;
        #1;
        check("mask_new",   32'(mul_mask), 32'h0F);
        check("mask_rv0",   32'(rsp_valid), 1);
        check("mask_id0",   32'(rsp_id), 3);
        check("mask_data0", 32'(rsp_data), 32'h00F0);
        tick();
        check("mask_rv1",   32'(rsp_valid), 1);
        check("mask_data1", 32'(rsp_data), 32'h00F0);
        tick();
        check("mask_drain", 32'(rsp_valid), 0);

        // NREQ=3 wrap and skip: set ptr to 1, then requesters 0 and 2 valid
        req_a3 = 24'h03_02_01;
        req_b3 = 24'h01_01_01;
        tick();
        req_valid3 = 3'b001;
        #1;
        check("wrap_g0", 32'(req_ready3), 32'h1);
        tick();
        req_valid3 = 3'b101;
        #1;
        check("wrap_g1", 32'(req_ready3), 32'h4);
        tick();
        check("wrap_g2",  32'(req_ready3), 32'h1);
        check("wrap_rv2", 32'(rsp_valid3), 1);
        check("wrap_id2", 32'(rsp_id3), 0);
        check("wrap_d2",  32'(rsp_data3), 1);
        tick();
        check("wrap_g3",  32'(req_ready3), 32'h4);
        check("wrap_id3", 32'(rsp_id3), 2);
        check("wrap_d3",  32'(rsp_data3), 3);
        tick();
        req_valid3 = '0;
        #1;
        check("wrap_g4",  32'(req_ready3), 0);
        check("wrap_id4", 32'(rsp_id3), 0);
        tick();
        check("wrap_id5", 32'(rsp_id3), 2);
        tick();
        check("wrap_drain", 32'(rsp_valid3), 0);

        // Reset with both stages full; mask of requester 0 changed beforehand
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_a     = 32'h0000_0007;
        req_b     = 32'h0000_0003;
        cfg_we    = 1'b1;
        cfg_id    = 2'd0;
        cfg_mask  = 7'h33;
        #1;
        check("rstop_ready0", 32'(req_ready), 32'h1);
        tick();
        cfg_we = 1'b0;
        #1;
        check("rstop_ready1", 32'(req_ready), 32'h1);
        check("rstop_mask",   32'(mul_mask), 32'h7F);
        tick();
        check("rstop_occ",    32'(occupancy), 2);
        check("rstop_ready2", 32'(req_ready), 0);
        check("rstop_rv",     32'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rstop_rv_low",  32'(rsp_valid), 0);
        check("rstop_occ_low", 32'(occupancy), 0);
        check("rstop_rdy_low", 32'(req_ready), 0);
        tick();
        check("rstop_rdy_hold", 32'(req_ready), 0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0011;
        req_a     = 32'h0000_0409;
        req_b     = 32'h0000_0202;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("post_rst_mask", 32'(mul_mask), 32'h7F);
        check("post_rst_a",    32'(mul_a), 32'h09);
        check("post_rst_rv0",  32'(rsp_valid), 0);
        tick();
        check("post_rst_rv",   32'(rsp_valid), 1);
        check("post_rst_id",   32'(rsp_id), 0);
        check("post_rst_data", 32'(rsp_data), 32'h0012);
        tick();
        check("post_rst_drain", 32'(rsp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
